// File: rtl/turf_pkg.sv
// Shared definitions for the round controller: field widths, colour codes,
// the controller state encoding and the winner tie-break helper.
package turf_pkg;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int ADDR_W = X_W + Y_W;

  // Last arena cell swept by CLEAR and SCAN (x=158, y=119)
  localparam logic [ADDR_W-1:0] DEFAULT_ADDR_LAST = 15'h4F77;

  localparam logic [2:0] COL_BLANK = 3'b000;
  localparam logic [2:0] COL_P1    = 3'b001;
  localparam logic [2:0] COL_P2    = 3'b010;
  localparam logic [2:0] COL_P3    = 3'b100;
  localparam logic [2:0] COL_P4    = 3'b110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_PAINT1,
    ST_PAINT2,
    ST_PAINT3,
    ST_PAINT4,
    ST_SCAN,
    ST_DRAIN,
    ST_DECIDE,
    ST_DONE
  } state_t;

  // Index of the largest count; only a strictly larger count displaces the
  // current best, so ties resolve to the lowest player index.
  function automatic logic [1:0] pick_winner(input logic [ADDR_W-1:0] c1,
                                             input logic [ADDR_W-1:0] c2,
                                             input logic [ADDR_W-1:0] c3,
                                             input logic [ADDR_W-1:0] c4);
    logic [1:0]        best;
    logic [ADDR_W-1:0] best_cnt;
    best     = 2'd0;
    best_cnt = c1;
    if (c2 > best_cnt) begin
      best     = 2'd1;
      best_cnt = c2;
    end
    if (c3 > best_cnt) begin
      best     = 2'd2;
      best_cnt = c3;
    end
    if (c4 > best_cnt) begin
      best = 2'd3;
    end
    return best;
  endfunction

endpackage

// File: rtl/round_controller_if.sv
// Single-port paint RAM bus. The controller is the master and drives
// address, write data and write enable; the RAM returns read data.
interface round_controller_if;
  import turf_pkg::*;

  logic [ADDR_W-1:0] ram_address;
  logic [2:0]        ram_data;
  logic              ram_wren;
  logic [2:0]        ram_rdata;

  modport master (output ram_address, output ram_data, output ram_wren,
                  input  ram_rdata);
  modport slave  (input  ram_address, input  ram_data, input  ram_wren,
                  output ram_rdata);
endinterface

// File: rtl/round_controller_score_tally.sv
// score_tally: tags returning SCAN reads with a valid shift register that
// matches the RAM read latency, counts cells per player colour, and latches
// the winning index when told to decide.
module score_tally
  import turf_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              issue,
  input  logic              decide,
  input  logic [2:0]        rdata,
  output logic [ADDR_W-1:0] p1_count,
  output logic [ADDR_W-1:0] p2_count,
  output logic [ADDR_W-1:0] p3_count,
  output logic [ADDR_W-1:0] p4_count,
  output logic [1:0]        winner
);

  logic [RD_LATENCY-1:0] vld;

  // Delay each issued read by the RAM latency so the tail bit marks valid rdata
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      vld <= '0;
    end else begin
      vld[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Count tagged cells by colour; blank and unknown codes are ignored
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      p1_count <= '0;
      p2_count <= '0;
      p3_count <= '0;
      p4_count <= '0;
    end else if (vld[RD_LATENCY-1]) begin
      case (rdata)
        COL_P1:  p1_count <= p1_count + ADDR_W'(1);
        COL_P2:  p2_count <= p2_count + ADDR_W'(1);
        COL_P3:  p3_count <= p3_count + ADDR_W'(1);
        COL_P4:  p4_count <= p4_count + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Latch the winner once all reads have retired
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      winner <= 2'd0;
    end else if (decide) begin
      winner <= pick_winner(p1_count, p2_count, p3_count, p4_count);
    end
  end

endmodule

// File: rtl/round_controller.sv
// round_controller: owns the paint RAM port and sequences one game round
// (CLEAR, RUN/PAINT, SCAN, DRAIN, DECIDE, DONE).
// Optional feature macro ROUND_PAUSE_EN adds a 'pause' input that freezes
// tick acceptance while in RUN.
module round_controller
  import turf_pkg::*;
#(
  parameter int                ROUND_TICKS = 3600,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = DEFAULT_ADDR_LAST,
  parameter int                RD_LATENCY  = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 move_tick,
`ifdef ROUND_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic [ADDR_W-1:0]    p1,
  input  logic [ADDR_W-1:0]    p2,
  input  logic [ADDR_W-1:0]    p3,
  input  logic [ADDR_W-1:0]    p4,
  round_controller_if.master   ram,
  output logic                 move_en,
  output logic                 running,
  output logic [ADDR_W-1:0]    p1_count,
  output logic [ADDR_W-1:0]    p2_count,
  output logic [ADDR_W-1:0]    p3_count,
  output logic [ADDR_W-1:0]    p4_count,
  output logic [1:0]           winner,
  output logic                 winner_valid
);

  // A zero-length round still plays one tick
  localparam int EFF_TICKS = (ROUND_TICKS == 0) ? 1 : ROUND_TICKS;
  localparam int TICK_W    = $clog2(EFF_TICKS + 1);
  localparam int DRAIN_W   = $clog2(RD_LATENCY + 1);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               tick_ok;
  logic               clear_round;
  logic               issue;
  logic               decide;

`ifdef ROUND_PAUSE_EN
  assign tick_ok = move_tick & ~pause;
`else
  assign tick_ok = move_tick;
`endif

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the RAM/handshake outputs for the current state
  always_comb begin
    state_nxt       = state;
    ram.ram_wren    = 1'b0;
    ram.ram_address = '0;
    ram.ram_data    = COL_BLANK;
    move_en         = 1'b0;
    running         = 1'b0;
    winner_valid    = 1'b0;
    clear_round     = 1'b0;
    issue           = 1'b0;
    decide          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_CLEAR;
          clear_round = 1'b1;
        end
      end
      ST_CLEAR: begin
        ram.ram_wren    = 1'b1;
        ram.ram_address = addr_cnt;
        if (addr_cnt == ADDR_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        move_en = tick_ok;
        if (tick_ok) state_nxt = ST_PAINT1;
      end
      ST_PAINT1: begin
        running         = 1'b1;
        ram.ram_wren    = 1'b1;
        ram.ram_address = p1;
        ram.ram_data    = COL_P1;
        state_nxt       = ST_PAINT2;
      end
      ST_PAINT2: begin
        running         = 1'b1;
        ram.ram_wren    = 1'b1;
        ram.ram_address = p2;
        ram.ram_data    = COL_P2;
        state_nxt       = ST_PAINT3;
      end
      ST_PAINT3: begin
        running         = 1'b1;
        ram.ram_wren    = 1'b1;
        ram.ram_address = p3;
        ram.ram_data    = COL_P3;
        state_nxt       = ST_PAINT4;
      end
      ST_PAINT4: begin
        running         = 1'b1;
        ram.ram_wren    = 1'b1;
        ram.ram_address = p4;
        ram.ram_data    = COL_P4;
        if (tick_cnt == TICK_W'(EFF_TICKS)) state_nxt = ST_SCAN;
        else                                state_nxt = ST_RUN;
      end
      ST_SCAN: begin
        ram.ram_address = addr_cnt;
        issue           = 1'b1;
        if (addr_cnt == ADDR_LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_W'(RD_LATENCY - 1)) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        decide    = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        winner_valid = 1'b1;
        if (start) begin
          state_nxt   = ST_CLEAR;
          clear_round = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sweep address, accepted-tick and drain counters
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      addr_cnt  <= '0;
      tick_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (clear_round) begin
        addr_cnt <= '0;
        tick_cnt <= '0;
      end else begin
        if (state == ST_CLEAR || state == ST_SCAN) begin
          addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_W'(1);
        end
        if (state == ST_RUN && tick_ok) begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  score_tally #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tally (
    .clk      (CLOCK_50),
    .resetn   (resetn),
    .clear    (clear_round),
    .issue    (issue),
    .decide   (decide),
    .rdata    (ram.ram_rdata),
    .p1_count (p1_count),
    .p2_count (p2_count),
    .p3_count (p3_count),
    .p4_count (p4_count),
    .winner   (winner)
  );

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller with a 64-cell arena, 2-tick rounds and a
// 2-cycle behavioural RAM. Expected RAM writes are queued when stimulus is
// driven and compared as the controller performs them.
module tb_round_controller;
  import turf_pkg::*;

  localparam logic [ADDR_W-1:0] T_ADDR_LAST = 15'd63;
  localparam int                T_TICKS     = 2;
  localparam int                T_LAT       = 2;

  typedef struct {
    logic [14:0] p1;
    logic [14:0] p2;
    logic [14:0] p3;
    logic [14:0] p4;
    logic        drop;
    logic        exp_scan;
  } tick_vec_t;

  typedef struct {
    logic [14:0] c1;
    logic [14:0] c2;
    logic [14:0] c3;
    logic [14:0] c4;
    logic [1:0]  win;
  } result_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        move_tick;
  logic        pause;
  logic [14:0] p1, p2, p3, p4;
  logic        move_en;
  logic        running;
  logic [14:0] p1_count, p2_count, p3_count, p4_count;
  logic [1:0]  winner;
  logic        winner_valid;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb_q[$];
  tick_vec_t   ticks[6];
  result_t     results[2];

  round_controller_if ram_bus();

  round_controller #(
    .ROUND_TICKS (T_TICKS),
    .ADDR_LAST   (T_ADDR_LAST),
    .RD_LATENCY  (T_LAT)
  ) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .start        (start),
    .move_tick    (move_tick),
`ifdef ROUND_PAUSE_EN
    .pause        (pause),
`endif
    .p1           (p1),
    .p2           (p2),
    .p3           (p3),
    .p4           (p4),
    .ram          (ram_bus),
    .move_en      (move_en),
    .running      (running),
    .p1_count     (p1_count),
    .p2_count     (p2_count),
    .p3_count     (p3_count),
    .p4_count     (p4_count),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always #5 clk = ~clk;

  // Behavioural paint RAM with a 2-stage read pipeline
  logic [2:0] mem [0:32767];
  logic [2:0] rd_pipe [T_LAT];

  always @(posedge clk) begin
    if (ram_bus.ram_wren) mem[ram_bus.ram_address] <= ram_bus.ram_data;
    rd_pipe[0] <= mem[ram_bus.ram_address];
    for (int i = 1; i < T_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_bus.ram_rdata = rd_pipe[T_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every RAM write must match the oldest queued expectation
  always @(negedge clk) begin
    if (ram_bus.ram_wren === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=0x%0h/%0d required=none",
                 ram_bus.ram_address, ram_bus.ram_data);
      end else begin
        checkOutput("ram_write", 32'({ram_bus.ram_address, ram_bus.ram_data}),
                    32'(sb_q.pop_front()));
      end
    end
  end

  task automatic startRound();
    int n;
    @(posedge clk); #1;
    start = 1'b1;
    for (int a = 0; a <= 63; a++) sb_q.push_back({15'(a), COL_BLANK});
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (running !== 1'b1 && n < 200);
    checkOutput("clear_duration", 32'(n), 32'd65);
  endtask

  task automatic preloadArena();
    for (int i = 0; i < 10; i++) mem[i] <= COL_P1;
    for (int i = 10; i < 20; i++) mem[i] <= COL_P2;
    for (int i = 20; i < 23; i++) mem[i] <= COL_P3;
  endtask

  task automatic applyStimulus(input tick_vec_t v);
    @(posedge clk); #1;
    p1 = v.p1; p2 = v.p2; p3 = v.p3; p4 = v.p4;
    move_tick = 1'b1;
    sb_q.push_back({v.p1, COL_P1});
    sb_q.push_back({v.p2, COL_P2});
    sb_q.push_back({v.p3, COL_P3});
    sb_q.push_back({v.p4, COL_P4});
    @(negedge clk);
    checkOutput("tick_move_en", 32'(move_en), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      move_tick = 1'b0;
      if (i == 2 && v.drop) begin
        move_tick = 1'b1;
        @(negedge clk);
        checkOutput("paint_tick_move_en", 32'(move_en), 32'd0);
      end
    end
    @(negedge clk);
    checkOutput("running_after_paint", 32'(running), v.exp_scan ? 32'd0 : 32'd1);
  endtask

  task automatic waitResult(input result_t r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (winner_valid !== 1'b1 && n < 500);
    checkOutput("scan_duration", 32'(n), 32'd67);
    checkOutput("p1_count", 32'(p1_count), 32'(r.c1));
    checkOutput("p2_count", 32'(p2_count), 32'(r.c2));
    checkOutput("p3_count", 32'(p3_count), 32'(r.c3));
    checkOutput("p4_count", 32'(p4_count), 32'(r.c4));
    checkOutput("winner", 32'(winner), 32'(r.win));
    repeat (5) @(negedge clk);
    checkOutput("hold_winner_valid", 32'(winner_valid), 32'd1);
    checkOutput("hold_winner", 32'(winner), 32'(r.win));
    checkOutput("hold_p2_count", 32'(p2_count), 32'(r.c2));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; move_tick = 1'b0; pause = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;

    ticks[0] = '{15'd5, 15'd6, 15'd7, 15'd8, 1'b1, 1'b0};
    ticks[1] = '{15'd9, 15'd10, 15'd11, 15'd9, 1'b0, 1'b1};
    ticks[2] = '{15'd100, 15'd100, 15'd100, 15'd100, 1'b0, 1'b0};
    ticks[3] = '{15'd100, 15'd100, 15'd100, 15'd100, 1'b0, 1'b1};
    ticks[4] = '{15'd100, 15'd100, 15'd100, 15'd100, 1'b0, 1'b0};
    ticks[5] = '{15'd100, 15'd100, 15'd100, 15'd100, 1'b0, 1'b1};
    results[0] = '{15'd1, 15'd2, 15'd2, 15'd2, 2'd1};
    results[1] = '{15'd10, 15'd10, 15'd3, 15'd0, 2'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ram_wren", 32'(ram_bus.ram_wren), 32'd0);
    checkOutput("rst_ram_address", 32'(ram_bus.ram_address), 32'd0);
    checkOutput("rst_ram_data", 32'(ram_bus.ram_data), 32'd0);
    checkOutput("rst_move_en", 32'(move_en), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_winner_valid", 32'(winner_valid), 32'd0);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    checkOutput("rst_p1_count", 32'(p1_count), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    $display("[TB] round 1: painting with collision and dropped tick");
    startRound();
    applyStimulus(ticks[0]);
    applyStimulus(ticks[1]);
    waitResult(results[0]);

    $display("[TB] round 2: pre-loaded arena, tie between P1 and P2");
    startRound();
    checkOutput("restart_winner_valid", 32'(winner_valid), 32'd0);
    checkOutput("restart_p2_count", 32'(p2_count), 32'd0);
    preloadArena();
    applyStimulus(ticks[2]);
    applyStimulus(ticks[3]);
    waitResult(results[1]);

    $display("[TB] round 3: reset during SCAN");
    startRound();
    preloadArena();
    applyStimulus(ticks[4]);
    applyStimulus(ticks[5]);
    repeat (20) @(negedge clk);
    checkOutput("midscan_p1_count", 32'(p1_count), 32'd10);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort_running", 32'(running), 32'd0);
    checkOutput("abort_winner_valid", 32'(winner_valid), 32'd0);
    checkOutput("abort_p1_count", 32'(p1_count), 32'd0);
    checkOutput("abort_ram_address", 32'(ram_bus.ram_address), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    startRound();
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
